// File: rtl/gyro_angle_integrator_if.sv
// gyro_angle_integrator_if
//   Groups the rate-sample inputs, the control levels and the angle outputs
//   of gyro_angle_integrator into one bundle.
//   master : the gyro-side driver (drives samples/controls, reads angles)
//   slave  : the integrator itself
//   Signals:
//     sample_valid      gx/gy/gz valid this cycle
//     gx, gy, gz        signed rate samples (RATE_W bits)
//     recal_in          level, restart bias calibration
//     zero_in           level, force all angles to 0
//     pitch, roll, yaw  angles in degrees, 0..359
//     angle_valid       1-cycle pulse on a sample-driven update
//     calibrated        high once the bias is valid
interface gyro_angle_integrator_if #(
    parameter int RATE_W = 16
);
    logic                     sample_valid;
    logic signed [RATE_W-1:0] gx;
    logic signed [RATE_W-1:0] gy;
    logic signed [RATE_W-1:0] gz;
    logic                     recal_in;
    logic                     zero_in;
    logic [8:0]               pitch;
    logic [8:0]               roll;
    logic [8:0]               yaw;
    logic                     angle_valid;
    logic                     calibrated;

    modport master (
        output sample_valid, gx, gy, gz, recal_in, zero_in,
        input  pitch, roll, yaw, angle_valid, calibrated
    );

    modport slave (
        input  sample_valid, gx, gy, gz, recal_in, zero_in,
        output pitch, roll, yaw, angle_valid, calibrated
    );
endinterface

// File: rtl/gyro_angle_integrator.sv
// gyro_angle_integrator
//   Turns raw signed gyro rates into wrapped 0..359 degree pitch/roll/yaw.
//   CAL state averages 2**CAL_LOG2 samples per axis to get a bias; RUN state
//   removes the bias, applies a deadband (stage 1) and integrates into a
//   fixed-point accumulator with modulo-360 wrap (stage 2).
//   Ports:
//     clk_100mhz  system clock
//     rst_in      asynchronous active-high reset
//     bus         gyro_angle_integrator_if.slave (samples, controls, angles)
module gyro_angle_integrator #(
    parameter int RATE_W   = 16,
    parameter int CAL_LOG2 = 6,
    parameter int FRAC     = 10,
    parameter int DEADBAND = 8
) (
    input  logic                  clk_100mhz,
    input  logic                  rst_in,
    gyro_angle_integrator_if.slave bus
);

    localparam int SUM_W = RATE_W + CAL_LOG2;
    localparam int D_W   = RATE_W + 1;
    // 360 * 2**FRAC < 2**(FRAC+9); acc + d stays inside a signed FRAC+11 range
    localparam int ACC_W = FRAC + 11;

    localparam logic signed [ACC_W-1:0] FULL_TURN = ACC_W'(32'sd360) <<< FRAC;
    localparam logic signed [D_W-1:0]   DB_POS    = D_W'(DEADBAND);
    localparam logic signed [D_W-1:0]   DB_NEG    = -DB_POS;

    typedef enum logic [0:0] {
        ST_CAL = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    // Bias-removed rate with deadband applied.
    function automatic logic signed [D_W-1:0] debias(
        input logic signed [RATE_W-1:0] g,
        input logic signed [RATE_W-1:0] b
    );
        logic signed [D_W-1:0] d;
        d = {g[RATE_W-1], g} - {b[RATE_W-1], b};
        if ((d <= DB_POS) && (d >= DB_NEG)) begin
            d = '0;
        end else begin
            d = d;
        end
        return d;
    endfunction

    // Accumulate one delta with a single modulo-360 correction.
    function automatic logic signed [ACC_W-1:0] wrap_add(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [D_W-1:0]   d
    );
        logic signed [ACC_W-1:0] s;
        s = acc + ACC_W'(d);
        if (s >= FULL_TURN) begin
            s = s - FULL_TURN;
        end else if (s < $signed({ACC_W{1'b0}})) begin
            s = s + FULL_TURN;
        end else begin
            s = s;
        end
        return s;
    endfunction

    state_t                   state_r;
    logic [CAL_LOG2-1:0]      cal_count_r;
    logic signed [SUM_W-1:0]  sum_x_r, sum_y_r, sum_z_r;
    logic signed [RATE_W-1:0] bias_x_r, bias_y_r, bias_z_r;
    logic                     s1_valid_r;
    logic signed [D_W-1:0]    d_x_r, d_y_r, d_z_r;
    logic signed [ACC_W-1:0]  acc_x_r, acc_y_r, acc_z_r;
    logic [8:0]               pitch_r, roll_r, yaw_r;
    logic                     angle_valid_r;
    logic                     calibrated_r;

    logic signed [SUM_W-1:0]  sum_x_s, sum_y_s, sum_z_s;
    logic signed [ACC_W-1:0]  acc_x_s, acc_y_s, acc_z_s;

    // Next calibration sums and next accumulator values from stage 1.
    always_comb begin
        sum_x_s = sum_x_r + SUM_W'(bus.gx);
        sum_y_s = sum_y_r + SUM_W'(bus.gy);
        sum_z_s = sum_z_r + SUM_W'(bus.gz);
        acc_x_s = wrap_add(acc_x_r, d_x_r);
        acc_y_s = wrap_add(acc_y_r, d_y_r);
        acc_z_s = wrap_add(acc_z_r, d_z_r);
    end

    // Calibration FSM, deadband stage, integration stage and output registers.
    always_ff @(posedge clk_100mhz or posedge rst_in) begin
        if (rst_in) begin
            state_r       <= ST_CAL;
            cal_count_r   <= '0;
            sum_x_r       <= '0;
            sum_y_r       <= '0;
            sum_z_r       <= '0;
            bias_x_r      <= '0;
            bias_y_r      <= '0;
            bias_z_r      <= '0;
            s1_valid_r    <= 1'b0;
            d_x_r         <= '0;
            d_y_r         <= '0;
            d_z_r         <= '0;
            acc_x_r       <= '0;
            acc_y_r       <= '0;
            acc_z_r       <= '0;
            pitch_r       <= 9'd0;
            roll_r        <= 9'd0;
            yaw_r         <= 9'd0;
            angle_valid_r <= 1'b0;
            calibrated_r  <= 1'b0;
        end else begin
            angle_valid_r <= 1'b0;
            s1_valid_r    <= 1'b0;

            // Stage 2: a recalibration discards whatever is in stage 1.
            if (s1_valid_r && !bus.recal_in) begin
                acc_x_r       <= acc_x_s;
                acc_y_r       <= acc_y_s;
                acc_z_r       <= acc_z_s;
                pitch_r       <= acc_x_s[FRAC+8:FRAC];
                roll_r        <= acc_y_s[FRAC+8:FRAC];
                yaw_r         <= acc_z_s[FRAC+8:FRAC];
                angle_valid_r <= 1'b1;
            end

            // Zeroing overrides a coincident update but keeps its valid pulse.
            if (bus.zero_in) begin
                acc_x_r <= '0;
                acc_y_r <= '0;
                acc_z_r <= '0;
                pitch_r <= 9'd0;
                roll_r  <= 9'd0;
                yaw_r   <= 9'd0;
            end

            if (bus.recal_in) begin
                state_r      <= ST_CAL;
                cal_count_r  <= '0;
                sum_x_r      <= '0;
                sum_y_r      <= '0;
                sum_z_r      <= '0;
                calibrated_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_CAL: begin
                        if (bus.sample_valid) begin
                            sum_x_r     <= sum_x_s;
                            sum_y_r     <= sum_y_s;
                            sum_z_r     <= sum_z_s;
                            cal_count_r <= cal_count_r + CAL_LOG2'(1'b1);
                            if (&cal_count_r) begin
                                bias_x_r     <= RATE_W'(sum_x_s >>> CAL_LOG2);
                                bias_y_r     <= RATE_W'(sum_y_s >>> CAL_LOG2);
                                bias_z_r     <= RATE_W'(sum_z_s >>> CAL_LOG2);
                                state_r      <= ST_RUN;
                                calibrated_r <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (bus.sample_valid) begin
                            s1_valid_r <= 1'b1;
                            d_x_r      <= debias(bus.gx, bias_x_r);
                            d_y_r      <= debias(bus.gy, bias_y_r);
                            d_z_r      <= debias(bus.gz, bias_z_r);
                        end
                    end
                    default: begin
                        state_r      <= ST_CAL;
                        calibrated_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.pitch       = pitch_r;
    assign bus.roll        = roll_r;
    assign bus.yaw         = yaw_r;
    assign bus.angle_valid = angle_valid_r;
    assign bus.calibrated  = calibrated_r;

endmodule

// File: tb/tb_gyro_angle_integrator.sv
// Directed bench for gyro_angle_integrator: calibration, integration,
// deadband edges, wrap, streaming, recalibration, zeroing and reset.
module tb_gyro_angle_integrator;

    logic clk_100mhz = 1'b0;
    logic rst_in     = 1'b1;
    int   checks     = 0;
    int   errors     = 0;
    int   pulses;

    always #5 clk_100mhz = ~clk_100mhz;

    gyro_angle_integrator_if #(.RATE_W(16)) bus_if ();

    gyro_angle_integrator #(
        .RATE_W(16), .CAL_LOG2(6), .FRAC(10), .DEADBAND(8)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .rst_in    (rst_in),
        .bus       (bus_if)
    );

    task automatic step();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic drive(input logic v, input logic signed [15:0] x,
                         input logic signed [15:0] y, input logic signed [15:0] z);
        bus_if.sample_valid = v;
        bus_if.gx = x;
        bus_if.gy = y;
        bus_if.gz = z;
    endtask

    task automatic test_reset();
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        bus_if.recal_in = 1'b0;
        bus_if.zero_in  = 1'b0;
        rst_in = 1'b1;
        step(); step();
        checks++;
        if ({bus_if.pitch, bus_if.roll, bus_if.yaw} !== 27'd0) begin
            errors++; $display("FAIL reset_angles got %0d/%0d/%0d exp 0/0/0", bus_if.pitch, bus_if.roll, bus_if.yaw);
        end
        checks++;
        if ({bus_if.angle_valid, bus_if.calibrated} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got %b exp 00", {bus_if.angle_valid, bus_if.calibrated});
        end
        rst_in = 1'b0;
        step();
    endtask

    task automatic test_cal(input logic signed [15:0] x, input logic signed [15:0] y,
                            input logic signed [15:0] z, input string tag);
        pulses = 0;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, x, y, z);
            step();
            pulses += int'(bus_if.angle_valid);
            if (i == 62) begin
                checks++;
                if (bus_if.calibrated !== 1'b0) begin
                    errors++; $display("FAIL %s_cal_early got %b exp 0", tag, bus_if.calibrated);
                end
            end
        end
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        checks++;
        if (bus_if.calibrated !== 1'b1) begin
            errors++; $display("FAIL %s_cal_done got %b exp 1", tag, bus_if.calibrated);
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL %s_cal_no_valid got %0d exp 0", tag, pulses);
        end
    endtask

    task automatic test_integrate();
        drive(1'b1, 16'sd1124, -16'sd3, 16'sd0);
        step();
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        checks++;
        if (bus_if.angle_valid !== 1'b0) begin
            errors++; $display("FAIL int_latency1 got %b exp 0", bus_if.angle_valid);
        end
        step();
        checks++;
        if (bus_if.angle_valid !== 1'b1) begin
            errors++; $display("FAIL int_latency2 got %b exp 1", bus_if.angle_valid);
        end
        checks++;
        if ({bus_if.pitch, bus_if.roll, bus_if.yaw} !== {9'd1, 9'd0, 9'd0}) begin
            errors++; $display("FAIL int_angles got %0d/%0d/%0d exp 1/0/0", bus_if.pitch, bus_if.roll, bus_if.yaw);
        end
        step();
        checks++;
        if (bus_if.angle_valid !== 1'b0) begin
            errors++; $display("FAIL int_pulse_width got %b exp 0", bus_if.angle_valid);
        end
    endtask

    task automatic test_zero();
        bus_if.zero_in = 1'b1;
        step();
        bus_if.zero_in = 1'b0;
        checks++;
        if ({bus_if.pitch, bus_if.angle_valid} !== {9'd0, 1'b0}) begin
            errors++; $display("FAIL zero_idle got pitch %0d valid %b exp 0 0", bus_if.pitch, bus_if.angle_valid);
        end
    endtask

    task automatic run_x(input logic signed [15:0] x, input int n);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, x, -16'sd3, 16'sd0);
            step();
            pulses += int'(bus_if.angle_valid);
        end
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        step(); pulses += int'(bus_if.angle_valid);
        step(); pulses += int'(bus_if.angle_valid);
    endtask

    task automatic test_deadband();
        run_x(16'sd108, 1000);
        checks++;
        if (bus_if.pitch !== 9'd0) begin
            errors++; $display("FAIL db_pos_edge got %0d exp 0", bus_if.pitch);
        end
        checks++;
        if (pulses != 1000) begin
            errors++; $display("FAIL db_pulses got %0d exp 1000", pulses);
        end
        run_x(16'sd109, 1024);
        checks++;
        if (bus_if.pitch !== 9'd9) begin
            errors++; $display("FAIL db_pos_over got %0d exp 9", bus_if.pitch);
        end
        run_x(16'sd92, 1000);
        checks++;
        if (bus_if.pitch !== 9'd9) begin
            errors++; $display("FAIL db_neg_edge got %0d exp 9", bus_if.pitch);
        end
        run_x(16'sd91, 1024);
        checks++;
        if (bus_if.pitch !== 9'd0) begin
            errors++; $display("FAIL db_neg_over got %0d exp 0", bus_if.pitch);
        end
    endtask

    task automatic test_back_to_back();
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'sd100, 16'sd2045, 16'sd0);
            step();
            pulses += int'(bus_if.angle_valid);
        end
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        for (int i = 0; i < 3; i++) begin
            step();
            pulses += int'(bus_if.angle_valid);
        end
        checks++;
        if (pulses != 10) begin
            errors++; $display("FAIL stream_pulses got %0d exp 10", pulses);
        end
        checks++;
        if ({bus_if.pitch, bus_if.roll, bus_if.yaw} !== {9'd0, 9'd20, 9'd0}) begin
            errors++; $display("FAIL stream_angles got %0d/%0d/%0d exp 0/20/0", bus_if.pitch, bus_if.roll, bus_if.yaw);
        end
    endtask

    task automatic test_recal();
        drive(1'b1, 16'sd5220, -16'sd3, 16'sd0);
        step();
        bus_if.recal_in = 1'b1;
        step();
        bus_if.recal_in = 1'b0;
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        checks++;
        if ({bus_if.calibrated, bus_if.angle_valid} !== 2'b00) begin
            errors++; $display("FAIL recal_flags got %b exp 00", {bus_if.calibrated, bus_if.angle_valid});
        end
        step();
        checks++;
        if ({bus_if.angle_valid, bus_if.pitch, bus_if.roll} !== {1'b0, 9'd0, 9'd20}) begin
            errors++; $display("FAIL recal_discard got valid %b pitch %0d roll %0d exp 0 0 20", bus_if.angle_valid, bus_if.pitch, bus_if.roll);
        end
        test_cal(16'sd0, 16'sd0, 16'sd0, "recal");
        checks++;
        if ({bus_if.pitch, bus_if.roll, bus_if.yaw} !== {9'd0, 9'd20, 9'd0}) begin
            errors++; $display("FAIL recal_hold got %0d/%0d/%0d exp 0/20/0", bus_if.pitch, bus_if.roll, bus_if.yaw);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 16'sd0, 16'sd0, -16'sd1024);
        step();
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        step();
        checks++;
        if ({bus_if.angle_valid, bus_if.yaw} !== {1'b1, 9'd359}) begin
            errors++; $display("FAIL wrap_under got valid %b yaw %0d exp 1 359", bus_if.angle_valid, bus_if.yaw);
        end
        drive(1'b1, 16'sd0, 16'sd0, 16'sd1024);
        step();
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        step();
        checks++;
        if ({bus_if.yaw, bus_if.roll} !== {9'd0, 9'd20}) begin
            errors++; $display("FAIL wrap_over got yaw %0d roll %0d exp 0 20", bus_if.yaw, bus_if.roll);
        end
    endtask

    task automatic test_zero_coincident();
        drive(1'b1, 16'sd2048, 16'sd0, 16'sd0);
        step();
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        bus_if.zero_in = 1'b1;
        step();
        bus_if.zero_in = 1'b0;
        checks++;
        if (bus_if.angle_valid !== 1'b1) begin
            errors++; $display("FAIL zero_coinc_valid got %b exp 1", bus_if.angle_valid);
        end
        checks++;
        if ({bus_if.pitch, bus_if.roll, bus_if.yaw} !== 27'd0) begin
            errors++; $display("FAIL zero_coinc_angles got %0d/%0d/%0d exp 0/0/0", bus_if.pitch, bus_if.roll, bus_if.yaw);
        end
    endtask

    task automatic test_reset_midpipe();
        drive(1'b1, 16'sd3000, 16'sd0, 16'sd0);
        step();
        step();
        checks++;
        if ({bus_if.angle_valid, bus_if.pitch} !== {1'b1, 9'd2}) begin
            errors++; $display("FAIL pre_rst got valid %b pitch %0d exp 1 2", bus_if.angle_valid, bus_if.pitch);
        end
        drive(1'b0, 16'sd0, 16'sd0, 16'sd0);
        #1 rst_in = 1'b1;
        #1;
        checks++;
        if ({bus_if.angle_valid, bus_if.calibrated, bus_if.pitch} !== {1'b0, 1'b0, 9'd0}) begin
            errors++; $display("FAIL async_rst got valid %b cal %b pitch %0d exp 0 0 0", bus_if.angle_valid, bus_if.calibrated, bus_if.pitch);
        end
        step();
        rst_in = 1'b0;
        step();
        step();
        checks++;
        if ({bus_if.angle_valid, bus_if.calibrated, bus_if.pitch} !== {1'b0, 1'b0, 9'd0}) begin
            errors++; $display("FAIL post_rst got valid %b cal %b pitch %0d exp 0 0 0", bus_if.angle_valid, bus_if.calibrated, bus_if.pitch);
        end
    endtask

    initial begin
        test_reset();
        test_cal(16'sd100, -16'sd3, 16'sd0, "init");
        test_integrate();
        test_zero();
        test_deadband();
        test_back_to_back();
        test_recal();
        test_wrap();
        test_zero_coincident();
        test_reset_midpipe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
